// File: rtl/rtc_calibrator.sv
// rtl/rtc_calibrator.sv - PPS-referenced measurement of RTC clock cycles per second
//
// Purpose:
//   Counts clk_i cycles between rising edges of an external 1 PPS reference,
//   averages 2^AVG_LOG2 periods with round-half-up, range-checks every period
//   and hands the result to the RTC core as a one-cycle calibre_update_o
//   strobe qualifying calibre_sec_cnt_o.
//
// Ports:
//   clk_i              in   RTC clock
//   rstn_i             in   asynchronous active-low reset
//   pps_i              in   asynchronous 1 PPS reference
//   cal_start_i        in   start a calibration run (pulse, ignored while busy)
//   cal_abort_i        in   abort a running calibration (pulse, wins over start/pps)
//   calibre_update_o   out  one-cycle strobe, calibre_sec_cnt_o carries a new value
//   calibre_sec_cnt_o  out  last accepted calibration value (NOMINAL after reset)
//   cal_busy_o         out  high while a run is in progress
//   cal_done_o         out  one-cycle pulse when a run finishes (ok or error)
//   cal_err_o          out  sticky: last run failed; cleared by the next accepted start
//
// Build option:
//   RTC_CAL_GLITCH_FILTER_EN - when defined, the synchronized PPS level must be
//   stable for 4 consecutive samples before it is accepted, so pulses shorter
//   than 4 cycles never produce an edge. Undefined: the raw synchronized level
//   feeds the edge detector.

module rtc_calibrator #(
  parameter int AVG_LOG2    = 3,
  parameter int NOMINAL     = 32768,
  parameter int TOL         = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pps_i,
  input  logic        cal_start_i,
  input  logic        cal_abort_i,
  output logic        calibre_update_o,
  output logic [15:0] calibre_sec_cnt_o,
  output logic        cal_busy_o,
  output logic        cal_done_o,
  output logic        cal_err_o
);

  localparam int CNT_W = 17;
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] P_MIN    = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] P_MAX    = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2 * NOMINAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [ACC_W-1:0] HALF_LSB = ACC_W'(1 << (AVG_LOG2 - 1));
  localparam logic [15:0]      NOM_VAL  = 16'(NOMINAL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_CHECK
  } state_t;

  // ---------------------------------------------------------------------------
  // PPS synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pps_sync;
  logic                   edge_q, edge_d;

  assign pps_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pps_i};
  end

`ifdef RTC_CAL_GLITCH_FILTER_EN
  // filt_q only follows pps_sync once it has disagreed for 4 samples in a row;
  // fcnt_q counts the disagreeing samples seen so far.
  logic       filt_q, filt_d;
  logic [1:0] fcnt_q, fcnt_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = 2'd0;
    if (pps_sync != filt_q) begin
      if (fcnt_q == 2'd3) begin
        filt_d = pps_sync;
      end else begin
        fcnt_d = fcnt_q + 2'd1;
      end
    end
    // The filter flop already acts as the delay stage of the edge detector.
    edge_d = filt_d & ~filt_q;
  end
`else
  logic dly_q, dly_d;

  always_comb begin
    dly_d  = pps_sync;
    edge_d = pps_sync & ~dly_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // Measurement state machine
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               upd_q, upd_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [15:0]        val_q, val_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               period_ok;
  logic               timed_out;

  always_comb begin
    // Saturate so a stuck reference can never wrap into a plausible period.
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    period_ok = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
    timed_out = (cnt_q >= TIMEOUT);

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    val_d   = val_q;

    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous abort cancels the start request.
        if (cal_start_i && !cal_abort_i) begin
          state_d = ST_ARM;
          err_d   = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          idx_d   = '0;
        end
      end

      ST_ARM: begin
        // The counter doubles as the timeout timer while waiting for the first edge.
        if (cal_abort_i) begin
          state_d = ST_IDLE;
        end else if (edge_q) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (timed_out) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_MEASURE: begin
        if (cal_abort_i) begin
          state_d = ST_IDLE;
        end else if (edge_q) begin
          if (!period_ok) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            acc_d = acc_q + ACC_W'(cnt_q);
            idx_d = idx_q + 1'b1;
            cnt_d = CNT_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d = ST_CHECK;
            end
          end
        end else if (timed_out) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_CHECK: begin
        if (cal_abort_i) begin
          state_d = ST_IDLE;
        end else begin
          // Round half up; every period passed the range check, so the mean fits 16 bits.
          val_d   = 16'((acc_q + HALF_LSB) >> AVG_LOG2);
          upd_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
`ifdef RTC_CAL_GLITCH_FILTER_EN
      filt_q  <= 1'b0;
      fcnt_q  <= 2'd0;
`else
      dly_q   <= 1'b0;
`endif
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      val_q   <= NOM_VAL;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
`ifdef RTC_CAL_GLITCH_FILTER_EN
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
`else
      dly_q   <= dly_d;
`endif
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      val_q   <= val_d;
    end
  end

  assign calibre_update_o  = upd_q;
  assign calibre_sec_cnt_o = val_q;
  assign cal_busy_o        = busy_q;
  assign cal_done_o        = done_q;
  assign cal_err_o         = err_q;

endmodule
